// File: rtl/config_ctrl_if.sv
// config_ctrl_if: bus bundle between a configuration requester and config_ctrl.
// The master drives the request side; the controller (slave) drives the
// committed configuration and status back.
interface config_ctrl_if #(
    parameter int CFG_W = 35,
    parameter int KEY_W = 2
);
    logic             request;
    logic             confirm;
    logic [KEY_W-1:0] password;
    logic [KEY_W-1:0] syskey;
    logic [CFG_W-1:0] configin;
    logic [CFG_W-1:0] configout;
    logic             write_en;
    logic             auth_fail;
    logic             locked;
    logic [2:0]       dbg_state;

    modport master (
        output request, confirm, password, syskey, configin,
        input  configout, write_en, auth_fail, locked, dbg_state
    );

    modport slave (
        input  request, confirm, password, syskey, configin,
        output configout, write_en, auth_fail, locked, dbg_state
    );
endinterface

// File: rtl/config_ctrl.sv
// config_ctrl: password-gated configuration register controller.
// A requester authenticates against the system key, a configuration word is
// captured into a shadow register, and it is committed to configout only after
// an explicit confirm (one-cycle write_en strobe). MAX_TRIES consecutive bad
// passwords lock the controller for LOCK_CYCLES clocks.
// Optional feature macro: CFG_CONFIRM_TIMEOUT_EN -- when defined, REQUEST is
// abandoned after CONFIRM_TIMEOUT clocks without confirm; when undefined the
// timeout counter is not built and REQUEST waits indefinitely.
module config_ctrl #(
    parameter int CFG_W           = 35,
    parameter int KEY_W           = 2,
    parameter int MAX_TRIES       = 3,
    parameter int LOCK_CYCLES     = 32,
    parameter int CONFIRM_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         arst,
    config_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_ACTIVE  = 3'b001,
        ST_REQUEST = 3'b010,
        ST_COMMIT  = 3'b011,
        ST_LOCKED  = 3'b100
    } state_t;

    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_TRIES);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    // Parameters below 1 make the counters meaningless; reject at elaboration.
    if (MAX_TRIES < 1 || LOCK_CYCLES < 1 || CONFIRM_TIMEOUT < 1) begin : g_bad_param
        $error("config_ctrl: MAX_TRIES, LOCK_CYCLES and CONFIRM_TIMEOUT must be >= 1");
    end

    state_t             state_q, state_d;
    logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [FAIL_W-1:0]  fail_inc_s;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [CFG_W-1:0]   configout_q, configout_d;
    logic               write_en_q, write_en_d;
    logic               auth_fail_q, auth_fail_d;
    logic               locked_q, locked_d;
`ifdef CFG_CONFIRM_TIMEOUT_EN
    localparam int TO_W = $clog2(CONFIRM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(CONFIRM_TIMEOUT - 1);
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`endif

    // fail_cnt stays below MAX_TRIES while in IDLE, so the increment cannot wrap.
    assign fail_inc_s = fail_cnt_q + {{(FAIL_W-1){1'b0}}, 1'b1};

    // Next-state, counter and output-register update logic.
    always_comb begin
        state_d     = state_q;
        fail_cnt_d  = fail_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        shadow_d    = shadow_q;
        configout_d = configout_q;
        auth_fail_d = 1'b0;
`ifdef CFG_CONFIRM_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.request) begin
                    if (bus.password == bus.syskey) begin
                        state_d    = ST_ACTIVE;
                        fail_cnt_d = {FAIL_W{1'b0}};
                    end else begin
                        auth_fail_d = 1'b1;
                        fail_cnt_d  = fail_inc_s;
                        if (fail_inc_s == FAIL_MAX) begin
                            state_d    = ST_LOCKED;
                            lock_cnt_d = {LOCK_W{1'b0}};
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.request) begin
                    state_d  = ST_REQUEST;
                    shadow_d = bus.configin;
`ifdef CFG_CONFIRM_TIMEOUT_EN
                    to_cnt_d = {TO_W{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                // Abort beats confirm; confirm beats the timeout.
                if (!bus.request) begin
                    state_d = ST_IDLE;
                end else if (bus.confirm) begin
                    state_d     = ST_COMMIT;
                    configout_d = shadow_q;
                end else begin
`ifdef CFG_CONFIRM_TIMEOUT_EN
                    if (to_cnt_q == TO_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = ST_REQUEST;
`endif
                end
            end
            ST_COMMIT: begin
                state_d = ST_ACTIVE;
            end
            ST_LOCKED: begin
                if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = ST_IDLE;
                    fail_cnt_d = {FAIL_W{1'b0}};
                    lock_cnt_d = {LOCK_W{1'b0}};
                end else begin
                    lock_cnt_d = lock_cnt_q + {{(LOCK_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        write_en_d = (state_d == ST_COMMIT);
        locked_d   = (state_d == ST_LOCKED);
    end

    // State, counters, shadow and registered outputs.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= ST_IDLE;
            fail_cnt_q  <= {FAIL_W{1'b0}};
            lock_cnt_q  <= {LOCK_W{1'b0}};
            shadow_q    <= {CFG_W{1'b0}};
            configout_q <= {CFG_W{1'b0}};
            write_en_q  <= 1'b0;
            auth_fail_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fail_cnt_q  <= fail_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            shadow_q    <= shadow_d;
            configout_q <= configout_d;
            write_en_q  <= write_en_d;
            auth_fail_q <= auth_fail_d;
            locked_q    <= locked_d;
        end
    end

`ifdef CFG_CONFIRM_TIMEOUT_EN
    // Confirm-timeout counter, only present when the timeout is enabled.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            to_cnt_q <= {TO_W{1'b0}};
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    assign bus.configout = configout_q;
    assign bus.write_en  = write_en_q;
    assign bus.auth_fail = auth_fail_q;
    assign bus.locked    = locked_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_config_ctrl.sv
// tb_config_ctrl: directed scoreboard bench for config_ctrl.
// Stimulus pushes the expected post-edge outputs per cycle and the expected
// value of each commit; a monitor pops and compares after every rising edge.
module tb_config_ctrl;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_ACTIVE  = 3'b001;
    localparam logic [2:0] S_REQUEST = 3'b010;
    localparam logic [2:0] S_COMMIT  = 3'b011;
    localparam logic [2:0] S_LOCKED  = 3'b100;
    localparam logic [1:0] KEY       = 2'b10;
    localparam logic [1:0] BAD       = 2'b00;

    typedef struct {
        logic [2:0]  st;
        logic        we;
        logic        af;
        logic        lk;
        logic [34:0] co;
    } exp_t;

    logic clk;
    logic arst;
    int   n_vec;
    int   n_fail;
    exp_t exp_q[$];
    logic [34:0] com_q[$];
    exp_t e_mon;
    logic [34:0] co_mon;
    logic [34:0] hold_v;

    config_ctrl_if #(.CFG_W(35), .KEY_W(2)) bus ();

    config_ctrl #(
        .CFG_W(35), .KEY_W(2), .MAX_TRIES(3), .LOCK_CYCLES(32), .CONFIRM_TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [34:0] act, input logic [34:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endfunction

    // Drive one cycle of inputs, record what the outputs must be after the edge.
    task automatic step(input logic req, input logic conf, input logic [1:0] pw,
                        input logic [34:0] cin, input logic [2:0] st, input logic we,
                        input logic af, input logic lk, input logic [34:0] co);
        exp_t e;
        bus.request  = req;
        bus.confirm  = conf;
        bus.password = pw;
        bus.configin = cin;
        e.st = st; e.we = we; e.af = af; e.lk = lk; e.co = co;
        exp_q.push_back(e);
        if (we) com_q.push_back(co);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the per-cycle trace and every commit strobe.
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            chk("dbg_state", {32'd0, bus.dbg_state}, {32'd0, e_mon.st});
            chk("write_en",  {34'd0, bus.write_en},  {34'd0, e_mon.we});
            chk("auth_fail", {34'd0, bus.auth_fail}, {34'd0, e_mon.af});
            chk("locked",    {34'd0, bus.locked},    {34'd0, e_mon.lk});
            chk("configout", bus.configout, e_mon.co);
        end
        if (bus.write_en === 1'b1) begin
            if (com_q.size() > 0) begin
                co_mon = com_q.pop_front();
                chk("commit_value", bus.configout, co_mon);
            end else begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write: configout %h with no commit expected", bus.configout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_fail = 0;
        arst = 1'b0;
        bus.request = 1'b0; bus.confirm = 1'b0; bus.password = BAD;
        bus.syskey = KEY; bus.configin = 35'h0;
        @(posedge clk);
        #2;

        // Reset held with inputs toggling.
        step(1'b1, 1'b1, KEY, 35'h7_FFFF_FFFF, S_IDLE, 1'b0, 1'b0, 1'b0, 35'h0);
        bus.syskey = 2'b01;
        step(1'b0, 1'b1, BAD, 35'h3000, S_IDLE, 1'b0, 1'b0, 1'b0, 35'h0);
        step(1'b1, 1'b0, 2'b01, 35'h1, S_IDLE, 1'b0, 1'b0, 1'b0, 35'h0);
        bus.syskey = KEY;
        step(1'b1, 1'b1, BAD, 35'h5_5555_5555, S_IDLE, 1'b0, 1'b0, 1'b0, 35'h0);
        arst = 1'b1;
        step(1'b0, 1'b0, BAD, 35'h0, S_IDLE, 1'b0, 1'b0, 1'b0, 35'h0);

        // Good commit of 35'h3000, then a capture-hold commit.
        step(1'b1, 1'b0, KEY, 35'h3000, S_ACTIVE,  1'b0, 1'b0, 1'b0, 35'h0);
        step(1'b1, 1'b0, KEY, 35'h3000, S_REQUEST, 1'b0, 1'b0, 1'b0, 35'h0);
        step(1'b1, 1'b1, KEY, 35'h3000, S_COMMIT,  1'b1, 1'b0, 1'b0, 35'h3000);
        step(1'b1, 1'b0, KEY, 35'h3000, S_ACTIVE,  1'b0, 1'b0, 1'b0, 35'h3000);
        step(1'b1, 1'b0, KEY, 35'h3000, S_REQUEST, 1'b0, 1'b0, 1'b0, 35'h3000);
        step(1'b1, 1'b0, KEY, 35'h1007, S_REQUEST, 1'b0, 1'b0, 1'b0, 35'h3000);
        step(1'b1, 1'b1, KEY, 35'h1007, S_COMMIT,  1'b1, 1'b0, 1'b0, 35'h3000);
        step(1'b0, 1'b0, KEY, 35'h1007, S_ACTIVE,  1'b0, 1'b0, 1'b0, 35'h3000);
        step(1'b0, 1'b0, KEY, 35'h1007, S_IDLE,    1'b0, 1'b0, 1'b0, 35'h3000);

        // Commit with the top configuration bit set.
        step(1'b1, 1'b0, KEY, 35'h4_0000_0001, S_ACTIVE,  1'b0, 1'b0, 1'b0, 35'h3000);
        step(1'b1, 1'b0, KEY, 35'h4_0000_0001, S_REQUEST, 1'b0, 1'b0, 1'b0, 35'h3000);
        step(1'b1, 1'b1, KEY, 35'h0,           S_COMMIT,  1'b1, 1'b0, 1'b0, 35'h4_0000_0001);
        step(1'b0, 1'b0, KEY, 35'h0,           S_ACTIVE,  1'b0, 1'b0, 1'b0, 35'h4_0000_0001);
        hold_v = 35'h4_0000_0001;

        // Abort beats confirm on the same edge.
        step(1'b1, 1'b0, KEY, 35'h7FF, S_REQUEST, 1'b0, 1'b0, 1'b0, hold_v);
        step(1'b0, 1'b1, KEY, 35'h7FF, S_IDLE,    1'b0, 1'b0, 1'b0, hold_v);

        // Unanswered request: timeout (or indefinite wait), then abort.
        step(1'b1, 1'b0, KEY, 35'h123, S_ACTIVE,  1'b0, 1'b0, 1'b0, hold_v);
        step(1'b1, 1'b0, KEY, 35'h123, S_REQUEST, 1'b0, 1'b0, 1'b0, hold_v);
`ifdef CFG_CONFIRM_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, KEY, 35'h123, (i < 16) ? S_REQUEST : S_IDLE,
                 1'b0, 1'b0, 1'b0, hold_v);
        end
`else
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 1'b0, KEY, 35'h123, S_REQUEST, 1'b0, 1'b0, 1'b0, hold_v);
        end
        step(1'b0, 1'b0, KEY, 35'h123, S_IDLE, 1'b0, 1'b0, 1'b0, hold_v);
`endif

        // Confirm on what would be the timeout edge still commits.
        step(1'b1, 1'b0, KEY, 35'h0AB, S_ACTIVE,  1'b0, 1'b0, 1'b0, hold_v);
        step(1'b1, 1'b0, KEY, 35'h0AB, S_REQUEST, 1'b0, 1'b0, 1'b0, hold_v);
        for (int i = 1; i <= 15; i++) begin
            step(1'b1, 1'b0, KEY, 35'h0AB, S_REQUEST, 1'b0, 1'b0, 1'b0, hold_v);
        end
        step(1'b1, 1'b1, KEY, 35'h0AB, S_COMMIT, 1'b1, 1'b0, 1'b0, 35'h0AB);
        step(1'b0, 1'b0, KEY, 35'h0AB, S_ACTIVE, 1'b0, 1'b0, 1'b0, 35'h0AB);
        step(1'b0, 1'b0, KEY, 35'h0AB, S_IDLE,   1'b0, 1'b0, 1'b0, 35'h0AB);

        // Successful auth clears the failure count.
        step(1'b1, 1'b0, BAD, 35'h0, S_IDLE,   1'b0, 1'b1, 1'b0, 35'h0AB);
        step(1'b1, 1'b0, BAD, 35'h0, S_IDLE,   1'b0, 1'b1, 1'b0, 35'h0AB);
        step(1'b1, 1'b0, KEY, 35'h0, S_ACTIVE, 1'b0, 1'b0, 1'b0, 35'h0AB);
        step(1'b0, 1'b0, KEY, 35'h0, S_IDLE,   1'b0, 1'b0, 1'b0, 35'h0AB);
        step(1'b1, 1'b0, BAD, 35'h0, S_IDLE,   1'b0, 1'b1, 1'b0, 35'h0AB);
        step(1'b1, 1'b0, KEY, 35'h0, S_ACTIVE, 1'b0, 1'b0, 1'b0, 35'h0AB);
        step(1'b0, 1'b0, KEY, 35'h0, S_IDLE,   1'b0, 1'b0, 1'b0, 35'h0AB);

        // Lockout after three failures; correct password ignored while locked.
        step(1'b1, 1'b0, BAD, 35'h0, S_IDLE,   1'b0, 1'b1, 1'b0, 35'h0AB);
        step(1'b1, 1'b0, BAD, 35'h0, S_IDLE,   1'b0, 1'b1, 1'b0, 35'h0AB);
        step(1'b1, 1'b0, BAD, 35'h0, S_LOCKED, 1'b0, 1'b1, 1'b1, 35'h0AB);
        for (int i = 2; i <= 32; i++) begin
            step(1'b1, 1'b1, KEY, 35'h1, S_LOCKED, 1'b0, 1'b0, 1'b1, 35'h0AB);
        end
        step(1'b1, 1'b1, KEY, 35'h1, S_IDLE,   1'b0, 1'b0, 1'b0, 35'h0AB);
        step(1'b1, 1'b0, KEY, 35'h1, S_ACTIVE, 1'b0, 1'b0, 1'b0, 35'h0AB);

        // Reset asserted during COMMIT clears configout at once.
        step(1'b1, 1'b0, KEY, 35'h2A, S_REQUEST, 1'b0, 1'b0, 1'b0, 35'h0AB);
        step(1'b1, 1'b1, KEY, 35'h2A, S_COMMIT,  1'b1, 1'b0, 1'b0, 35'h2A);
        arst = 1'b0;
        #1;
        chk("rst_configout", bus.configout, 35'h0);
        chk("rst_write_en", {34'd0, bus.write_en}, 35'h0);
        chk("rst_state", {32'd0, bus.dbg_state}, {32'd0, S_IDLE});
        step(1'b1, 1'b1, KEY, 35'h2A, S_IDLE, 1'b0, 1'b0, 1'b0, 35'h0);
        arst = 1'b1;
        step(1'b0, 1'b0, KEY, 35'h0, S_IDLE,   1'b0, 1'b0, 1'b0, 35'h0);
        step(1'b1, 1'b0, KEY, 35'h0, S_ACTIVE, 1'b0, 1'b0, 1'b0, 35'h0);
        step(1'b0, 1'b0, KEY, 35'h0, S_IDLE,   1'b0, 1'b0, 1'b0, 35'h0);

        repeat (3) @(posedge clk);
        #2;
        chk("commit_queue_drained", 35'(com_q.size()), 35'h0);
        chk("trace_queue_drained", 35'(exp_q.size()), 35'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
